// File: rtl/alu_arbiter_if.sv
// Bundle of every handshake and data signal around alu_arbiter.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The requester side must not derive req_valid from req_ready, and a
//   requester that is valid but not granted keeps its fields stable.
//   rsp_valid/rsp_id/rsp_result/rsp_zero/rsp_overflow stay stable while
//   rsp_valid is 1 and rsp_ready is 0.
//
// The "master" modport is the environment: requesters, the response
// consumer and the shared ALU. The "slave" modport is the arbiter itself.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    // Requester channel
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*4-1:0]  req_control;
    logic [NUM_REQ*32-1:0] req_left;
    logic [NUM_REQ*32-1:0] req_right;

    // Shared ALU drive and return
    logic [3:0]            alu_control;
    logic [31:0]           alu_left;
    logic [31:0]           alu_right;
    logic [31:0]           alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;
    logic                  rsp_overflow;

    modport master (
        output req_valid, req_control, req_left, req_right,
        output alu_result, alu_zero, alu_overflow,
        output rsp_ready,
        input  req_ready,
        input  alu_control, alu_left, alu_right,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow
    );

    modport slave (
        input  req_valid, req_control, req_left, req_right,
        input  alu_result, alu_zero, alu_overflow,
        input  rsp_ready,
        output req_ready,
        output alu_control, alu_left, alu_right,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ
// requesters. At most one operation is granted per cycle, its operands are
// steered to the ALU in the same cycle, and the ALU outputs are captured in
// a single registered response slot tagged with the requester id.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_arbiter_if.slave  bus
);

    // Priority pointer: requester searched first on the next grant.
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;

    // Grant decision
    logic               slot_free;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic               grant;
    logic [NUM_REQ-1:0] grant_vec;

    // Steered ALU inputs
    logic [3:0]         alu_control_mux;
    logic [31:0]        alu_left_mux;
    logic [31:0]        alu_right_mux;

    // Response slot
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [31:0]        rsp_result_q;
    logic               rsp_zero_q;
    logic               rsp_overflow_q;

    // The slot can take a new result when it is empty or being drained now.
    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    // Search for the first valid requester starting at ptr, wrapping around.
    always_comb begin
        logic [ID_W:0]   cand_sum;
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (cand_sum >= (ID_W + 1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W + 1)'(NUM_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A grant needs a request, a free slot, and reset released.
    assign grant = reset_n && slot_free && grant_found;

    // Expand the granted index into the one-hot ready vector.
    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_vec[i] = grant && (grant_idx == ID_W'(i));
        end
    end

    // Steer the granted requester's operation to the ALU; zeros when idle.
    always_comb begin
        alu_control_mux = 4'h0;
        alu_left_mux    = 32'h0;
        alu_right_mux   = 32'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i]) begin
                alu_control_mux = bus.req_control[i*4 +: 4];
                alu_left_mux    = bus.req_left[i*32 +: 32];
                alu_right_mux   = bus.req_right[i*32 +: 32];
            end
        end
    end

    // Next pointer sits just past the granted requester.
    assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                        : grant_idx + 1'b1;

    // Priority pointer advances only on a grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= ptr_next;
        end
    end

    // Response slot: load on grant, drop valid on drain, data otherwise holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_result_q   <= 32'h0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else if (grant) begin
            rsp_valid_q    <= 1'b1;
            rsp_id_q       <= grant_idx;
            rsp_result_q   <= bus.alu_result;
            rsp_zero_q     <= bus.alu_zero;
            rsp_overflow_q <= bus.alu_overflow;
        end else if (bus.rsp_ready) begin
            rsp_valid_q    <= 1'b0;
        end
    end

    assign bus.req_ready    = grant_vec;
    assign bus.alu_control  = alu_control_mux;
    assign bus.alu_left     = alu_left_mux;
    assign bus.alu_right    = alu_right_mux;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_overflow_q;

    // Ready is never asserted for more than one requester.
    a_ready_onehot: assert property (@(posedge clk) $onehot0(grant_vec));

    // No grant may be issued while the slot is stalled by the consumer.
    a_no_grant_stalled: assert property (@(posedge clk)
        (rsp_valid_q && !bus.rsp_ready) |-> (grant_vec == '0));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with two requesters and a behavioural ALU.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int IW = $clog2(N);

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;

    logic clk = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    alu_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

    alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ALU behaviour: {overflow, zero, result} ----------------
    function automatic logic [33:0] alu_fn(input logic [3:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'h0;
        v = 1'b0;
        case (c)
            ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            default: r = 32'h0;
        endcase
        return {v, (r == 32'h0), r};
    endfunction

    assign {bus.alu_overflow, bus.alu_zero, bus.alu_result} =
        alu_fn(bus.alu_control, bus.alu_left, bus.alu_right);

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] c,
                           input logic [31:0] l, input logic [31:0] r);
        bus.req_control[i*4 +: 4]  = c;
        bus.req_left[i*32 +: 32]   = l;
        bus.req_right[i*32 +: 32]  = r;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy);
        bus.req_valid = v;
        bus.rsp_ready = rdy;
        #1;
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    // Model state: whether a response is held, what it holds, and which
    // requester has first claim on the next grant.
    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    int          m_id    = 0;
    logic [31:0] m_res   = 32'h0;
    logic        m_zero  = 1'b0;
    logic        m_ovf   = 1'b0;

    always @(negedge clk) begin
        int          g;
        int          c;
        logic [33:0] op;
        logic [3:0]  e_ctl;
        logic [31:0] e_l;
        logic [31:0] e_r;
        g = -1;
        if (reset_n && (!m_valid || bus.rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
        end
        e_ctl = 4'h0;
        e_l   = 32'h0;
        e_r   = 32'h0;
        if (g >= 0) begin
            e_ctl = bus.req_control[g*4 +: 4];
            e_l   = bus.req_left[g*32 +: 32];
            e_r   = bus.req_right[g*32 +: 32];
        end
        check("req_ready",   32'(bus.req_ready),   (g >= 0) ? (32'h1 << g) : 32'h0);
        check("alu_control", 32'(bus.alu_control), 32'(e_ctl));
        check("alu_left",    bus.alu_left,         e_l);
        check("alu_right",   bus.alu_right,        e_r);
        check("rsp_valid",   32'(bus.rsp_valid),   32'(m_valid));
        check("rsp_id",      32'(bus.rsp_id),      32'(m_id));
        check("rsp_result",  bus.rsp_result,       m_res);
        check("rsp_zero",    32'(bus.rsp_zero),    32'(m_zero));
        check("rsp_ovf",     32'(bus.rsp_overflow), 32'(m_ovf));

        if (!reset_n) begin
            m_ptr = 0; m_valid = 1'b0; m_id = 0;
            m_res = 32'h0; m_zero = 1'b0; m_ovf = 1'b0;
        end else if (g >= 0) begin
            op      = alu_fn(e_ctl, e_l, e_r);
            m_valid = 1'b1;
            m_id    = g;
            m_res   = op[31:0];
            m_zero  = op[32];
            m_ovf   = op[33];
            m_ptr   = (g + 1) % N;
        end else if (bus.rsp_ready) begin
            m_valid = 1'b0;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    int rr_exp [6] = '{1, 2, 1, 2, 1, 2};
    logic [1:0] tv [16] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b10,
                            2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11};
    logic       tr [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        reset_n         = 1'b0;
        bus.req_valid   = '0;
        bus.rsp_ready   = 1'b1;
        bus.req_control = '0;
        bus.req_left    = '0;
        bus.req_right   = '0;
        set_req(0, ALU_SUB, 32'd9, 32'd4);
        set_req(1, ALU_SUB, 32'd7, 32'd2);

        // Reset held two cycles with both requesters valid.
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(2'b11, 1'b1);
            check("rst_req_ready", 32'(bus.req_ready), 32'h0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            check("rst_rsp_result", bus.rsp_result, 32'h0);
            check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        end

        // First grant after release goes to requester 0.
        tick();
        reset_n = 1'b1;
        drive(2'b11, 1'b1);
        check("first_grant", 32'(bus.req_ready), 32'h1);

        // Single add on requester 1 with signed overflow.
        tick();
        set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        drive(2'b10, 1'b1);
        check("add_grant", 32'(bus.req_ready), 32'h2);
        tick();
        drive(2'b00, 1'b1);
        check("add_valid", 32'(bus.rsp_valid), 32'h1);
        check("add_id", 32'(bus.rsp_id), 32'h1);
        check("add_result", bus.rsp_result, 32'h8000_0000);
        check("add_ovf", 32'(bus.rsp_overflow), 32'h1);
        check("add_zero", 32'(bus.rsp_zero), 32'h0);

        // Round-robin: both requesters hold SUB ops for six cycles.
        set_req(0, ALU_SUB, 32'd100, 32'd1);
        set_req(1, ALU_SUB, 32'd50, 32'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(2'b11, 1'b1);
            check("rr_grant", 32'(bus.req_ready), 32'(rr_exp[i]));
            if (i > 0) begin
                check("rr_valid", 32'(bus.rsp_valid), 32'h1);
                check("rr_id", 32'(bus.rsp_id), 32'(rr_exp[i-1] - 1));
            end
        end
        tick();
        drive(2'b00, 1'b1);
        check("rr_last_id", 32'(bus.rsp_id), 32'h1);
        check("rr_last_res", bus.rsp_result, 32'd47);

        // Backpressure: XOR on requester 0, then consumer stalls.
        tick();
        set_req(0, ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
        drive(2'b01, 1'b1);
        check("xor_grant", 32'(bus.req_ready), 32'h1);
        set_req(1, ALU_ADD, 32'd5, 32'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(2'b10, 1'b0);
            check("bp_ready", 32'(bus.req_ready), 32'h0);
            check("bp_result", bus.rsp_result, 32'hF0F0_0F0F);
            check("bp_valid", 32'(bus.rsp_valid), 32'h1);
        end
        tick();
        drive(2'b10, 1'b1);
        check("bp_release_grant", 32'(bus.req_ready), 32'h2);
        tick();
        drive(2'b00, 1'b1);
        check("bp_after_id", 32'(bus.rsp_id), 32'h1);
        check("bp_after_res", bus.rsp_result, 32'd11);

        // Zero flag from an equal-operand subtract.
        tick();
        set_req(0, ALU_SUB, 32'h1234_5678, 32'h1234_5678);
        drive(2'b01, 1'b1);
        check("zero_grant", 32'(bus.req_ready), 32'h1);
        tick();
        drive(2'b00, 1'b1);
        check("zero_result", bus.rsp_result, 32'h0);
        check("zero_flag", 32'(bus.rsp_zero), 32'h1);
        check("zero_ovf", 32'(bus.rsp_overflow), 32'h0);

        // Reset mid-flight: pointer is at 1 when reset hits.
        tick();
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        drive(2'b01, 1'b1);
        check("mf_grant", 32'(bus.req_ready), 32'h1);
        tick();
        reset_n = 1'b0;
        drive(2'b11, 1'b0);
        check("mf_valid_before", 32'(bus.rsp_valid), 32'h1);
        check("mf_result_before", bus.rsp_result, 32'd3);
        check("mf_ready_in_reset", 32'(bus.req_ready), 32'h0);
        tick();
        reset_n = 1'b1;
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        drive(2'b11, 1'b1);
        check("mf_valid_after", 32'(bus.rsp_valid), 32'h0);
        check("mf_result_after", bus.rsp_result, 32'h0);
        check("mf_ptr_reset", 32'(bus.req_ready), 32'h1);
        tick();
        drive(2'b00, 1'b1);
        check("mf_new_id", 32'(bus.rsp_id), 32'h0);
        check("mf_new_res", bus.rsp_result, 32'd30);
        tick();
        drive(2'b00, 1'b1);
        check("mf_drained", 32'(bus.rsp_valid), 32'h0);

        // Mixed directed table, checked by the per-cycle model.
        for (int i = 0; i < 16; i++) begin
            tick();
            set_req(0, 4'(i % 5), 32'h1357_9BDF * 32'(i + 1), 32'h0246_8ACE + 32'(i));
            set_req(1, 4'((i + 2) % 5), 32'h8000_0000 - 32'(i), 32'h7FFF_FFF0 + 32'(i * 3));
            drive(tv[i], tr[i]);
        end
        tick();
        drive(2'b00, 1'b1);
        tick();
        drive(2'b00, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one combinational `alu` instance between `NUM_REQ` requesters, such as the execute stage, branch-compare logic and the address-generation path. Each requester presents an operation over a valid/ready handshake. The arbiter grants at most one operation per cycle and drives it into the ALU. It captures the ALU outputs in a single registered response slot tagged with the requester id. The block sits between the requesters and the shared `alu`, which is instantiated outside it.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters. Legal range is 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester id.

Ports:
- `clk` input 1: clock. All state updates on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `req_valid` input `NUM_REQ`: bit i set means requester i holds an operation.
- `req_ready` output `NUM_REQ`: one-hot grant. Bit i set means requester i's operation is accepted this cycle.
- `req_control` input `NUM_REQ*4`: 4-bit ALU control per requester. Slice i is `[4i+3:4i]`, encoded with the `common` package ALU_* / B_* values.
- `req_left` input `NUM_REQ*32`: left operand per requester, slice `[32i+31:32i]`.
- `req_right` input `NUM_REQ*32`: right operand per requester, slice `[32i+31:32i]`.
- `alu_control` output 4: to the shared ALU `control` input.
- `alu_left` output 32: to the shared ALU `left_operand` input.
- `alu_right` output 32: to the shared ALU `right_operand` input.
- `alu_result` input 32: from ALU `result`.
- `alu_zero` input 1: from ALU `zero_flag`.
- `alu_overflow` input 1: from ALU `overflow`.
- `rsp_valid` output 1: the response slot holds a result.
- `rsp_ready` input 1: the consumer takes the response this cycle.
- `rsp_id` output `ID_W`: index of the requester that issued the operation.
- `rsp_result` output 32: registered ALU result.
- `rsp_zero` output 1: registered zero flag.
- `rsp_overflow` output 1: registered overflow flag.

## Operation

- **Slot free.** `slot_free = !rsp_valid || rsp_ready`. An operation can be granted only when the slot is free.
- **Grant selection.** When `slot_free` is set, grant `g` is the first i with `req_valid[i]` set, searching from priority pointer `ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready` is one-hot at `g`. It is all-zero if there is no request or the slot is not free.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **ALU drive on grant.** `alu_control/left/right` = requester g's fields, combinationally in the same cycle.
- **ALU drive with no grant.** `alu_control`, `alu_left` and `alu_right` are all 4'h0/32'h0. The ALU result in that cycle is ignored.
- **Pointer update.** On a grant, `ptr` ← (g+1) mod `NUM_REQ`. Without a grant, `ptr` holds.
- **Slot load.** On a grant, at the clock edge: `rsp_valid` ← 1, `rsp_id` ← g, and `rsp_result/zero/overflow` ← the ALU outputs.
- **Slot drain.** With no grant and `rsp_ready` set, `rsp_valid` ← 0 and the data fields hold their last value.
- **Backpressure.** While `rsp_valid && !rsp_ready`, all `rsp_*` outputs are stable and no grant is issued.
- **Simultaneous drain and grant.** A drain and a new grant in the same cycle replace the slot back-to-back, giving one result per cycle sustained.
- **Requester obligation.** A requester whose `req_valid` is set and which is not granted must hold its fields stable.

## Timing

- Latency is 1 cycle: grant in cycle N gives `rsp_valid` in cycle N+1.
- Throughput is 1 operation per cycle while `rsp_ready` stays high.
- Fairness: each continuously requesting requester is granted at least once every `NUM_REQ` grants.
- Reset (`reset_n` = 0 at an edge):
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_zero` = 0, `rsp_overflow` = 0, `ptr` = 0.
  - `req_ready` is forced to 0 during the reset cycle.
- Reset mid-operation discards the occupied slot and its result. No response is emitted for it.
- Reset wins over any simultaneous grant or drain.
- Arithmetic and flags are entirely the ALU's: 32-bit wrap-around, with overflow only for ALU_ADD/ALU_SUB. The arbiter passes these through unmodified.

## Test plan

- **Reset.** Hold `reset_n`=0 for 2 cycles with `req_valid`=2'b11 → `req_ready`=0, `rsp_valid`=0 and all `rsp_*`=0. After release, the first grant goes to requester 0.
- **Single add.** Requester 1 issues ALU_ADD with 32'h7FFF_FFFF + 32'h1 and `rsp_ready`=1 → `req_ready`=2'b10 that cycle. Next cycle: `rsp_valid`=1, `rsp_id`=1, `rsp_result`=32'h8000_0000, `rsp_overflow`=1, `rsp_zero`=0.
- **Round-robin.** Both requesters hold ALU_SUB requests continuously for 6 cycles with `rsp_ready`=1 → grants alternate 0,1,0,1,0,1. `rsp_id` follows one cycle later, and `rsp_valid` stays 1 each cycle.
- **Backpressure.**
  - Requester 0 issues ALU_XOR 32'hFFFF_0000 ^ 32'h0F0F_0F0F, then `rsp_ready`=0 for 3 cycles while requester 1 is valid → `rsp_result`=32'hF0F0_0F0F holds and `req_ready`=0 for 3 cycles.
  - When `rsp_ready` rises, requester 1 is granted that same cycle.
- **Zero flag.** ALU_SUB with 32'h1234_5678 − 32'h1234_5678 → `rsp_result`=0, `rsp_zero`=1, `rsp_overflow`=0.
- **Reset mid-flight.** Grant an operation, then assert `reset_n`=0 in the cycle its response is valid with `rsp_ready`=0 → `rsp_valid`=0 the following cycle, `ptr`=0, and no stale response appears after release.
